// File: rtl/ewrapper_io_rx_gearbox.sv
// ---------------------------------------------------------------------------
// ewrapper_io_rx_gearbox
//
// Receive-side 8:1 gearbox for the eLink. Each clock it takes one DDR bit
// pair (even = first on the wire, odd = second) from every LVDS lane. It then
// rebuilds byte-aligned words, with byte i coming from lane i. The top lane is
// the frame lane, and a 0->1 transition on it marks the first bit of a word.
// The serial order per lane is ..., prev odd, EVEN(t), ODD(t), EVEN(t+1), ...
//
// Parameters
//   LANES        number of lanes, frame lane is LANES-1, word is 8*LANES bits
//   IDLE_UNLOCK  consecutive all-zero frame bytes that drop the lock (1..255)
//
// Ports
//   CLK_IN              in   fast link clock, everything on its rising edge
//   IO_RESET_N          in   synchronous active-low reset
//   DATA_EVEN_IN        in   per-lane bit captured first
//   DATA_ODD_IN         in   per-lane bit captured second
//   DATA_OUT_TO_DEVICE  out  aligned word, lane i byte on [8i+7:8i], first
//                            received bit at [8i+7]; held between strobes
//   DATA_OUT_VALID      out  one-cycle strobe for a new word
//   RX_LOCKED           out  high while a byte boundary is held
//   RX_RESYNC           out  one-cycle pulse when the boundary drops or moves
//
// Configuration
//   EWRAPPER_RX_INVERT_EN  when defined, every incoming bit is inverted before
//                          frame detection and word assembly (counterpart of
//                          the transmit-side lane inversion).
// ---------------------------------------------------------------------------
module ewrapper_io_rx_gearbox #(
  parameter int LANES       = 9,
  parameter int IDLE_UNLOCK = 16
) (
  input  logic                 CLK_IN,
  input  logic                 IO_RESET_N,
  input  logic [LANES-1:0]     DATA_EVEN_IN,
  input  logic [LANES-1:0]     DATA_ODD_IN,
  output logic [8*LANES-1:0]   DATA_OUT_TO_DEVICE,
  output logic                 DATA_OUT_VALID,
  output logic                 RX_LOCKED,
  output logic                 RX_RESYNC
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_UNLOCK);

  // Registered state
  state_t             r_state;
  logic [1:0]         r_phase;
  logic               r_slip;
  logic [7:0]         r_idle;
  logic [6:0]         r_hist [LANES];
  logic [8*LANES-1:0] r_data;
  logic               r_valid;
  logic               r_resync;

  // Combinational helpers
  logic [LANES-1:0]   w_even;
  logic [LANES-1:0]   w_odd;
  logic [8*LANES-1:0] w_word;
  logic               w_prevFrame;
  logic               w_detEven;
  logic               w_detOdd;
  logic               w_detect;
  logic               w_detSlip;
  logic               w_onStart;
  logic               w_wordDone;
  logic               w_frameZero;
  logic [7:0]         w_idleInc;

  // Next-state values from the FSM
  state_t             w_nextState;
  logic [1:0]         w_nextPhase;
  logic               w_nextSlip;
  logic [7:0]         w_nextIdle;
  logic               w_load;
  logic               w_resync;

  // Optional lane inversion. Every later stage sees only the corrected
  // bits, so the frame edge is judged after inversion.
`ifdef EWRAPPER_RX_INVERT_EN
  assign w_even = ~DATA_EVEN_IN;
  assign w_odd  = ~DATA_ODD_IN;
`else
  assign w_even = DATA_EVEN_IN;
  assign w_odd  = DATA_ODD_IN;
`endif

  // Per-lane history of the last seven received bits, newest in bit 0.
  // A slip-0 word needs six older bits plus the current pair. A slip-1 word
  // needs seven older bits plus the current even bit.
  always_ff @(posedge CLK_IN) begin
    if (!IO_RESET_N) begin
      for (int i = 0; i < LANES; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        r_hist[i] <= {r_hist[i][4:0], w_even[i], w_odd[i]};
      end
    end
  end

  // Word assembly for the held slip, first received bit at the MSB of each
  // byte. The result is meaningful only in the cycle the word completes.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_slip) begin
        w_word[8*i +: 8] = {r_hist[i][6:0], w_even[i]};
      end else begin
        w_word[8*i +: 8] = {r_hist[i][5:0], w_even[i], w_odd[i]};
      end
    end
  end

  // Frame-lane boundary detection. The two cases cannot both be true,
  // because the even bit would have to be 1 and 0 at the same time.
  assign w_prevFrame = r_hist[LANES-1][0];
  assign w_detEven   = ~w_prevFrame & w_even[LANES-1];
  assign w_detOdd    = ~w_even[LANES-1] & w_odd[LANES-1];
  assign w_detect    = w_detEven | w_detOdd;
  assign w_detSlip   = w_detOdd;

  // The phase is 0 in the cycle after a detect, so the held word start
  // always falls on phase 3. A slip-0 word completes on phase 2, and a
  // slip-1 word completes one cycle later, on phase 3.
  assign w_onStart   = (r_phase == 2'd3) && (w_detSlip == r_slip);
  assign w_wordDone  = (r_phase == {1'b1, r_slip});
  assign w_frameZero = (w_word[8*LANES-1 -: 8] == 8'h00);
  assign w_idleInc   = r_idle + 8'd1;

  // Lock FSM next-state logic. A misaligned detect has the highest priority
  // and also drops the word in flight. Idle unlock comes next, and normal
  // phase advance last. The word that reaches the idle limit is still
  // delivered, in the same cycle as the resync pulse.
  always_comb begin
    w_nextState = r_state;
    w_nextPhase = r_phase;
    w_nextSlip  = r_slip;
    w_nextIdle  = r_idle;
    w_load      = 1'b0;
    w_resync    = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_detect) begin
          w_nextState = LOCKED;
          w_nextSlip  = w_detSlip;
          w_nextPhase = 2'd0;
          w_nextIdle  = 8'd0;
        end
      end
      LOCKED: begin
        w_nextPhase = r_phase + 2'd1;
        if (w_detect && !w_onStart) begin
          w_nextSlip  = w_detSlip;
          w_nextPhase = 2'd0;
          w_nextIdle  = 8'd0;
          w_resync    = 1'b1;
        end else if (w_wordDone) begin
          w_load     = 1'b1;
          w_nextIdle = w_frameZero ? w_idleInc : 8'd0;
          if (w_frameZero && (w_idleInc == IDLE_LIMIT)) begin
            w_nextState = HUNT;
            w_nextPhase = 2'd0;
            w_nextIdle  = 8'd0;
            w_resync    = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = HUNT;
      end
    endcase
  end

  // Lock FSM state, counters and registered outputs. The output word only
  // changes when a completed word is loaded.
  always_ff @(posedge CLK_IN) begin
    if (!IO_RESET_N) begin
      r_state  <= HUNT;
      r_phase  <= 2'd0;
      r_slip   <= 1'b0;
      r_idle   <= 8'd0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_resync <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_phase  <= w_nextPhase;
      r_slip   <= w_nextSlip;
      r_idle   <= w_nextIdle;
      r_valid  <= w_load;
      r_resync <= w_resync;
      if (w_load) begin
        r_data <= w_word;
      end
    end
  end

  assign DATA_OUT_TO_DEVICE = r_data;
  assign DATA_OUT_VALID     = r_valid;
  assign RX_LOCKED          = (r_state == LOCKED);
  assign RX_RESYNC          = r_resync;

endmodule

// File: tb/tb_ewrapper_io_rx_gearbox.sv
// ---------------------------------------------------------------------------
// tb_ewrapper_io_rx_gearbox
//
// Drives serial bit slots (one 9-bit column per wire bit, two per clock) into
// the receive gearbox. Expected words and resync pulses are queued, with the
// cycle in which they should appear, at the moment their final bit is driven.
// Build with EWRAPPER_RX_INVERT_EN to drive the complemented wire pattern
// instead.
// ---------------------------------------------------------------------------
module tb_ewrapper_io_rx_gearbox;

  logic        CLK_IN = 1'b0;
  logic        IO_RESET_N;
  logic [8:0]  DATA_EVEN_IN;
  logic [8:0]  DATA_ODD_IN;
  logic [71:0] DATA_OUT_TO_DEVICE;
  logic        DATA_OUT_VALID;
  logic        RX_LOCKED;
  logic        RX_RESYNC;

  always #5 CLK_IN = ~CLK_IN;

  ewrapper_io_rx_gearbox #(
    .LANES       (9),
    .IDLE_UNLOCK (16)
  ) dut (
    .CLK_IN             (CLK_IN),
    .IO_RESET_N         (IO_RESET_N),
    .DATA_EVEN_IN       (DATA_EVEN_IN),
    .DATA_ODD_IN        (DATA_ODD_IN),
    .DATA_OUT_TO_DEVICE (DATA_OUT_TO_DEVICE),
    .DATA_OUT_VALID     (DATA_OUT_VALID),
    .RX_LOCKED          (RX_LOCKED),
    .RX_RESYNC          (RX_RESYNC)
  );

`ifdef EWRAPPER_RX_INVERT_EN
  localparam logic [8:0] IN_MASK = 9'h1FF;
`else
  localparam logic [8:0] IN_MASK = 9'h000;
`endif

  typedef struct {
    logic [8:0]  bits;
    logic        endFlag;
    logic [71:0] word;
    logic        resync;
    logic        chkLock;
    logic        lockVal;
  } slot_t;

  typedef struct {
    int          cyc;
    logic [71:0] word;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  frame;
  } vec_t;

  slot_t slotQ[$];
  exp_t  sbQ[$];
  int    rsQ[$];
  int    vecCount  = 0;
  int    missCount = 0;
  int    cyc       = 0;
  vec_t  vecs[8];

  function automatic slot_t blankSlot(input logic [8:0] bits);
    slot_t s;
    s.bits    = bits;
    s.endFlag = 1'b0;
    s.word    = '0;
    s.resync  = 1'b0;
    s.chkLock = 1'b0;
    s.lockVal = 1'b0;
    return s;
  endfunction

  function automatic logic [63:0] rand64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic checkEq(input string name, input logic [71:0] got, input logic [71:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] e, input logic [8:0] o);
    DATA_EVEN_IN = e ^ IN_MASK;
    DATA_ODD_IN  = o ^ IN_MASK;
    @(negedge CLK_IN);
  endtask

  // Compare strobes and data against the scoreboard for the cycle just driven
  task automatic checkOutput(input logic chk, input logic lockVal);
    logic expV;
    logic expR;
    expV = 1'b0;
    expR = 1'b0;
    if (sbQ.size() > 0) begin
      if (sbQ[0].cyc == cyc) expV = 1'b1;
    end
    if (rsQ.size() > 0) begin
      if (rsQ[0] == cyc) expR = 1'b1;
    end
    checkEq("valid", {71'd0, DATA_OUT_VALID}, {71'd0, expV});
    if (expV) begin
      checkEq("data", DATA_OUT_TO_DEVICE, sbQ[0].word);
      sbQ.delete(0);
    end
    checkEq("resync", {71'd0, RX_RESYNC}, {71'd0, expR});
    if (expR) rsQ.delete(0);
    if (chk) checkEq("locked", {71'd0, RX_LOCKED}, {71'd0, lockVal});
  endtask

  task automatic flush();
    slot_t a;
    slot_t b;
    logic  chk;
    logic  lv;
    while (slotQ.size() > 0) begin
      a = slotQ.pop_front();
      if (slotQ.size() > 0) b = slotQ.pop_front();
      else b = blankSlot(9'h000);
      if (a.endFlag) sbQ.push_back('{cyc: cyc, word: a.word});
      if (b.endFlag) sbQ.push_back('{cyc: cyc, word: b.word});
      if (a.resync || b.resync) rsQ.push_back(cyc);
      chk = a.chkLock | b.chkLock;
      lv  = a.chkLock ? a.lockVal : b.lockVal;
      applyStimulus(a.bits, b.bits);
      checkOutput(chk, lv);
      cyc++;
    end
  endtask

  task automatic pushFill(input int n, input logic frameBit, input logic chk, input logic lv);
    slot_t s;
    for (int i = 0; i < n; i++) begin
      s = blankSlot({frameBit, 8'($urandom)});
      if (i == 0) begin
        s.chkLock = chk;
        s.lockVal = lv;
      end
      slotQ.push_back(s);
    end
  endtask

  // Serialise one word MSB first on every lane; it is always expected out
  task automatic pushWord(input logic [71:0] w, input logic firstResync, input logic lastResync,
                          input logic chk, input logic lv);
    slot_t      s;
    logic [8:0] bits;
    for (int b = 7; b >= 0; b--) begin
      for (int i = 0; i < 9; i++) bits[i] = w[8*i + b];
      s = blankSlot(bits);
      if (b == 7) begin
        s.resync  = firstResync;
        s.chkLock = chk;
        s.lockVal = lv;
      end
      if (b == 0) begin
        s.endFlag = 1'b1;
        s.word    = w;
        s.resync  = lastResync;
      end
      slotQ.push_back(s);
    end
  endtask

  task automatic doReset(input int n);
    checkEq("pending", 72'(sbQ.size() + rsQ.size()), 72'd0);
    sbQ.delete();
    rsQ.delete();
    slotQ.delete();
    IO_RESET_N   = 1'b0;
    DATA_EVEN_IN = 9'h1FF;
    DATA_ODD_IN  = 9'h1FF;
    repeat (n) begin
      @(negedge CLK_IN);
      cyc++;
    end
    checkEq("rst_data", DATA_OUT_TO_DEVICE, 72'd0);
    checkEq("rst_valid", {71'd0, DATA_OUT_VALID}, 72'd0);
    checkEq("rst_locked", {71'd0, RX_LOCKED}, 72'd0);
    checkEq("rst_resync", {71'd0, RX_RESYNC}, 72'd0);
    IO_RESET_N = 1'b1;
  endtask

  task automatic runTable(input int slip);
    doReset(2);
    pushFill(2 + slip, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      pushWord({vecs[k].frame, vecs[k].data}, 1'b0, 1'b0, k == 0, 1'b1);
    end
    flush();
    checkEq("table_locked", {71'd0, RX_LOCKED}, 72'd1);
  endtask

  initial begin
    // Frame bytes are monotone 1..10..0, so each word has only the edge at its start
    vecs[0] = '{data: 64'h0123_4567_89AB_CDA5, frame: 8'hFF};
    vecs[1] = '{data: 64'hDEAD_BEEF_CAFE_F00D, frame: 8'hFF};
    vecs[2] = '{data: 64'h8000_0000_0000_0001, frame: 8'hF0};
    vecs[3] = '{data: 64'h5A5A_A5A5_3C3C_C3C3, frame: 8'h80};
    vecs[4] = '{data: 64'hFFFF_FFFF_FFFF_FFFF, frame: 8'h00};
    vecs[5] = '{data: 64'h0000_0000_0000_0000, frame: 8'hC0};
    vecs[6] = '{data: 64'h1357_9BDF_2468_ACE0, frame: 8'hFE};
    vecs[7] = '{data: 64'h7E7E_0101_FEFE_8080, frame: 8'hFF};

    IO_RESET_N   = 1'b0;
    DATA_EVEN_IN = '0;
    DATA_ODD_IN  = '0;
    @(negedge CLK_IN);

    // Reset, then an idle frame lane: nothing may be produced
    $display("[TB] reset and idle");
    doReset(3);
    pushFill(20, 1'b0, 1'b0, 1'b0);
    flush();
    checkEq("idle_locked", {71'd0, RX_LOCKED}, 72'd0);
    checkEq("idle_data", DATA_OUT_TO_DEVICE, 72'd0);

    $display("[TB] table on even boundary");
    runTable(0);
    $display("[TB] table on odd boundary");
    runTable(1);

    // 15 idle words, a frame word clears the count, then 16 idle words unlock
    $display("[TB] idle unlock");
    doReset(2);
    pushFill(2, 1'b0, 1'b0, 1'b0);
    pushWord({8'hFF, rand64()}, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 15; k++) pushWord({8'h00, rand64()}, 1'b0, 1'b0, 1'b0, 1'b0);
    pushWord({8'h80, rand64()}, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) pushWord({8'h00, rand64()}, 1'b0, k == 16, 1'b0, 1'b0);
    pushFill(2, 1'b0, 1'b1, 1'b0);
    pushFill(16, 1'b0, 1'b0, 1'b0);
    flush();

    // Frame edge on an odd bit while held on even: realign, old word dropped
    $display("[TB] misalign");
    doReset(2);
    pushFill(2, 1'b0, 1'b0, 1'b0);
    pushWord({8'hFF, rand64()}, 1'b0, 1'b0, 1'b1, 1'b1);
    pushFill(3, 1'b0, 1'b0, 1'b0);
    pushWord({8'hFF, rand64()}, 1'b1, 1'b0, 1'b1, 1'b1);
    pushWord({8'hF0, rand64()}, 1'b0, 1'b0, 1'b0, 1'b0);
    flush();
    checkEq("misalign_locked", {71'd0, RX_LOCKED}, 72'd1);

    // Reset in the middle of a word, then relock after a quiet gap
    $display("[TB] reset mid-word");
    doReset(2);
    pushFill(2, 1'b0, 1'b0, 1'b0);
    pushWord({8'hFF, 64'hA5A5_5A5A_0F0F_F0F0}, 1'b0, 1'b0, 1'b0, 1'b0);
    pushFill(4, 1'b1, 1'b0, 1'b0);
    flush();
    doReset(1);
    pushFill(20, 1'b0, 1'b0, 1'b0);
    pushWord({8'hFF, rand64()}, 1'b0, 1'b0, 1'b1, 1'b1);
    flush();

    // Frame high on the very first bit after reset counts as an edge
    $display("[TB] edge right after reset");
    doReset(2);
    pushWord({8'hFF, rand64()}, 1'b0, 1'b0, 1'b1, 1'b1);
    pushWord({8'hC0, rand64()}, 1'b0, 1'b0, 1'b0, 1'b0);
    flush();
    checkEq("end_pending", 72'(sbQ.size() + rsQ.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
